// File: rtl/fp_mul_d_wb.sv
// Writeback queue for the double-precision multiplier: classifies each result
// into IEEE exception flags on accept and accrues them into fflags as entries retire.
module fp_mul_d_wb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic [63:0] in_res,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_res,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_flags,
    output logic [4:0]  fflags,
    input  logic        fflags_clr
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

    // Operand / result classification; sign bits do not affect any flag.
    logic unused_sign;
    assign unused_sign = ^{in_a[63], in_b[63], in_res[63]};

    logic exp_max_a, exp_max_b, exp_max_r;
    logic frac_nz_a, frac_nz_b, frac_nz_r;
    logic nan_a, nan_b, snan_a, snan_b;
    logic inf_a, inf_b, inf_r;
    logic zero_a, zero_b, zero_r;
    logic flag_nv, flag_of, flag_uf;
    logic [4:0] flags_in;

    always_comb begin
        exp_max_a = (in_a[62:52] == 11'h7FF);
        exp_max_b = (in_b[62:52] == 11'h7FF);
        exp_max_r = (in_res[62:52] == 11'h7FF);
        frac_nz_a = |in_a[51:0];
        frac_nz_b = |in_b[51:0];
        frac_nz_r = |in_res[51:0];
        nan_a     = exp_max_a && frac_nz_a;
        nan_b     = exp_max_b && frac_nz_b;
        snan_a    = nan_a && !in_a[51];
        snan_b    = nan_b && !in_b[51];
        inf_a     = exp_max_a && !frac_nz_a;
        inf_b     = exp_max_b && !frac_nz_b;
        inf_r     = exp_max_r && !frac_nz_r;
        zero_a    = (in_a[62:0] == 63'd0);
        zero_b    = (in_b[62:0] == 63'd0);
        zero_r    = (in_res[62:0] == 63'd0);
        flag_nv   = snan_a || snan_b || (inf_a && zero_b) || (inf_b && zero_a);
        flag_of   = inf_r && !(inf_a || nan_a || inf_b || nan_b);
        // The multiplier flushes tiny results to zero, so a zero from non-zero finite inputs is underflow.
        flag_uf   = zero_r && !(zero_a || inf_a || nan_a || zero_b || inf_b || nan_b);
        flags_in  = {flag_nv, 1'b0, flag_of, flag_uf, flag_of | flag_uf};
    end

    logic [63:0]   mem_res   [DEPTH];
    logic [4:0]    mem_rd    [DEPTH];
    logic [4:0]    mem_flags [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [4:0]    fflags_q;
    state_t        state, state_nxt;
    logic          push, pop;

    // Status is registered so in_ready never looks at out_ready.
    assign in_ready  = !rst && (state != S_FULL);
    assign out_valid = !rst && (state != S_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_res   = out_valid ? mem_res[rd_ptr]   : 64'd0;
    assign out_rd    = out_valid ? mem_rd[rd_ptr]    : 5'd0;
    assign out_flags = out_valid ? mem_flags[rd_ptr] : 5'd0;
    assign fflags    = rst ? 5'd0 : fflags_q;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
        if (count_nxt == '0)
            state_nxt = S_EMPTY;
        else if (count_nxt == FULL_CNT)
            state_nxt = S_FULL;
        else
            state_nxt = S_PARTIAL;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_res[wr_ptr]   <= in_res;
            mem_rd[wr_ptr]    <= in_rd;
            mem_flags[wr_ptr] <= flags_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= S_EMPTY;
            fflags_q <= 5'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            state <= state_nxt;
            if (pop)
                fflags_q <= (fflags_clr ? 5'd0 : fflags_q) | out_flags;
            else if (fflags_clr)
                fflags_q <= 5'd0;
        end
    end
endmodule

// File: tb/tb_fp_mul_d_wb.sv
// Directed bench for fp_mul_d_wb: flag classification table plus queue
// backpressure, flag clear/accrue and reset sequences.
module tb_fp_mul_d_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a, in_b, in_res;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_res;
    logic [4:0]  out_rd;
    logic [4:0]  out_flags;
    logic [4:0]  fflags;
    logic        fflags_clr;

    fp_mul_d_wb #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_res(in_res), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_rd(out_rd), .out_flags(out_flags),
        .fflags(fflags), .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [4:0]  rd;
        logic [4:0]  flags;
    } vec_t;

    vec_t        vecs [11];
    int          checks = 0;
    int          passed = 0;
    logic [4:0]  exp_ff;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] res, input logic [4:0] rd);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_res   = res;
        in_rd    = rd;
    endtask

    initial begin
        // {a, b, res, rd, flags {NV,DZ,OF,UF,NX}}
        vecs[0]  = '{64'h3FF0000000000000, 64'h4000000000000000, 64'h4000000000000000, 5'd5,  5'b00000};
        vecs[1]  = '{64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 5'd1,  5'b10000};
        vecs[2]  = '{64'h7FE0000000000000, 64'h7FE0000000000000, 64'h7FF0000000000000, 5'd2,  5'b00101};
        vecs[3]  = '{64'h0010000000000000, 64'h0010000000000000, 64'h0000000000000000, 5'd3,  5'b00011};
        vecs[4]  = '{64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'd4,  5'b10000};
        vecs[5]  = '{64'h7FF8000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 5'd6,  5'b00000};
        vecs[6]  = '{64'h8000000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 5'd7,  5'b10000};
        vecs[7]  = '{64'h7FF0000000000000, 64'h4000000000000000, 64'h7FF0000000000000, 5'd8,  5'b00000};
        vecs[8]  = '{64'h0000000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 5'd9,  5'b00000};
        vecs[9]  = '{64'h0000000000000001, 64'h3FF0000000000000, 64'h0000000000000000, 5'd10, 5'b00011};
        vecs[10] = '{64'hFFE0000000000000, 64'h7FE0000000000000, 64'hFFF0000000000000, 5'd31, 5'b00101};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_res = '0; in_rd = '0;
        out_ready = 1'b0; fflags_clr = 1'b0;
        step();
        step();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_fflags", {59'd0, fflags}, 64'd0);
        check("rst_out_res", out_res, 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("empty_out_flags", {59'd0, out_flags}, 64'd0);

        // Single-entry flow through the table: 1-cycle latency, pop, flag accrual.
        exp_ff = 5'd0;
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].rd);
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("v%0d_out_res", i), out_res, vecs[i].res);
            check($sformatf("v%0d_out_rd", i), {59'd0, out_rd}, {59'd0, vecs[i].rd});
            check($sformatf("v%0d_out_flags", i), {59'd0, out_flags}, {59'd0, vecs[i].flags});
            exp_ff = exp_ff | vecs[i].flags;
            step();
            check($sformatf("v%0d_fflags", i), {59'd0, fflags}, {59'd0, exp_ff});
            check($sformatf("v%0d_drained", i), {63'd0, out_valid}, 64'd0);
        end
        out_ready = 1'b0;

        // Clear without pop, then NV accrues, then clear coinciding with a UF pop.
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        check("clr_no_pop", {59'd0, fflags}, 64'd0);
        drive(vecs[1].a, vecs[1].b, vecs[1].res, vecs[1].rd);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("nv_accrued", {59'd0, fflags}, 64'h10);
        drive(vecs[3].a, vecs[3].b, vecs[3].res, vecs[3].rd);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("uf_head_flags", {59'd0, out_flags}, 64'h03);
        out_ready = 1'b1;
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        out_ready = 1'b0;
        check("clr_with_pop", {59'd0, fflags}, 64'h03);

        // Backpressure with DEPTH=2: third push waits for the first pop.
        drive(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h1111, 5'd1);
        step();
        check("bp_ready_after_1", {63'd0, in_ready}, 64'd1);
        drive(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h2222, 5'd2);
        step();
        check("bp_full_ready", {63'd0, in_ready}, 64'd0);
        check("bp_head_1", out_res, 64'h1111);
        drive(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h3333, 5'd3);
        step();
        check("bp_hold_head", out_res, 64'h1111);
        check("bp_hold_rd", {59'd0, out_rd}, 64'd1);
        check("bp_still_full", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
        check("bp_head_2", out_res, 64'h2222);
        step();
        in_valid = 1'b0;
        check("bp_full_again", {63'd0, in_ready}, 64'd0);
        check("bp_head_2_held", out_res, 64'h2222);
        out_ready = 1'b1;
        step();
        check("bp_head_3", out_res, 64'h3333);
        check("bp_head_3_rd", {59'd0, out_rd}, 64'd3);
        step();
        out_ready = 1'b0;
        check("bp_empty", {63'd0, out_valid}, 64'd0);
        check("bp_empty_res", out_res, 64'd0);

        // Reset with two entries queued and a push pending.
        drive(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4444, 5'd4);
        step();
        drive(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h5555, 5'd5);
        step();
        check("pre_rst_full", {63'd0, in_ready}, 64'd0);
        check("pre_rst_fflags", {59'd0, fflags}, 64'h03);
        rst = 1'b1;
        out_ready = 1'b1;
        fflags_clr = 1'b0;
        step();
        check("rst_q_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_q_fflags", {59'd0, fflags}, 64'd0);
        check("rst_q_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);
        check("rel_out_valid", {63'd0, out_valid}, 64'd0);
        check("rel_fflags", {59'd0, fflags}, 64'd0);
        check("rel_out_res", out_res, 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fp_mul_d_wb.md
FP_MUL_D_WB -- requirements
Module: fp_mul_d_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of result-queue entries (power of two, ≥2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream multiplier result is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the queue can accept an entry this cycle.
REQ-006 SHALL have port in_a, input, 64 bits: operand A presented to the double multiplier.
REQ-007 SHALL have port in_b, input, 64 bits: operand B presented to the double multiplier.
REQ-008 SHALL have port in_res, input, 64 bits: the double-precision product from the multiplier.
REQ-009 SHALL have port in_rd, input, 5 bits: destination register tag.
REQ-010 SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the register-file write port accepts the head entry.
REQ-012 SHALL have port out_res, output, 64 bits: the head result.
REQ-013 SHALL have port out_rd, output, 5 bits: the head destination tag.
REQ-014 SHALL have port out_flags, output, 5 bits: per-operation exception flags of the head entry, ordered {NV,DZ,OF,UF,NX}.
REQ-015 SHALL have port fflags, output, 5 bits: sticky accrued exception flags, in the same order.
REQ-016 SHALL have port fflags_clr, input, 1 bit: clears fflags.

Function
REQ-017 SHALL, at accept time, compute flags combinationally from in_a, in_b and in_res, and store them with in_res and in_rd.
REQ-018 SHALL set NV when either operand is a signalling NaN (exp=0x7FF, frac≠0, frac[51]=0), or when one operand is infinity and the other is ±0.
REQ-019 SHALL set OF when in_res is ±infinity and neither operand is infinity or NaN.
REQ-020 SHALL set UF when in_res is ±0 and neither operand is zero, infinity or NaN (the multiplier flushes underflow to zero).
REQ-021 SHALL set NX = OF | UF, and SHALL always drive DZ as 0.
REQ-022 SHALL implement a DEPTH-entry FIFO with read and write pointers that wrap modulo DEPTH, plus an occupancy counter of width clog2(DEPTH)+1.
REQ-023 SHALL treat occupancy as three status states: EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH).
REQ-024 SHALL drive in_ready = !rst && (count<DEPTH), with no combinational dependence on out_ready.
REQ-025 SHALL push when in_valid && in_ready, and SHALL pop when out_valid && out_ready.
REQ-026 SHALL, on a simultaneous push and pop in PARTIAL, perform both and leave count unchanged.
REQ-027 SHALL not push when FULL, even if a pop occurs in the same cycle.
REQ-028 SHALL provide no bypass path: latency from accept to out_valid is exactly 1 cycle when the queue is EMPTY.
REQ-029 SHALL drive out_valid = (count≠0), and SHALL drive out_res, out_rd and out_flags from the head entry.
REQ-030 SHALL hold head outputs stable while out_valid && !out_ready.
REQ-031 SHALL drive out_res, out_rd and out_flags as 0 when EMPTY.
REQ-032 SHALL preserve strict FIFO order.
REQ-033 SHALL accrue flags at pop time: on a pop, fflags <= (fflags_clr ? 0 : fflags) | out_flags.
REQ-034 SHALL, on fflags_clr without a pop, load fflags with 0.

Reset
REQ-035 SHALL, while rst=1 at a clock edge, clear count, pointers and fflags, discarding all queued entries including those mid-operation.
REQ-036 SHALL drive out_valid=0, in_ready=0, out_res=0, out_rd=0, out_flags=0 and fflags=0 during reset.
REQ-037 SHALL raise in_ready in the first cycle after rst deasserts.
REQ-038 SHALL give rst priority over push, pop and fflags_clr.

Verification
REQ-039 SHALL cover: a=0x3FF0000000000000, b=0x4000000000000000, res=0x4000000000000000, rd=5, out_ready=1 -> next cycle out_valid=1, out_res=0x4000000000000000, out_rd=5, out_flags=00000.
REQ-040 SHALL cover: a=0x7FF0000000000000, b=0, res=0x7FF8000000000000 -> out_flags=10000, and fflags=10000 after the pop.
REQ-041 SHALL cover: a=b=0x7FE0000000000000, res=0x7FF0000000000000 -> out_flags=00101; then a=b=0x0010000000000000, res=0 -> out_flags=00011, fflags=00111.
REQ-042 SHALL cover: out_ready=0, three back-to-back pushes with DEPTH=2 -> in_ready=0 after the second push; the third is accepted one cycle after the first pop; output order is 1,2,3.
REQ-043 SHALL cover: fflags=10000, fflags_clr=1 in the same cycle as a pop with out_flags=00011 -> fflags=00011.
REQ-044 SHALL cover: rst=1 with 2 entries queued -> next cycle out_valid=0, fflags=0; in_ready=1 one cycle after rst falls.
